alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the LC-3 datapath ALU.
//  - Keeps the four legacy ops on the same codes; adds SUB/OR/XOR/shifts and an iterative multiply.
//  - Registers result plus NZP/overflow flags, so the control FSM reads condition codes directly from it.
//  - Sits between the register file read ports and the bus mux; one request in flight at a time.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_mul_iter.sv | 46 ++++
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq block: opcode encoding, FSM states
// and the post-reset condition-code value.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_AND   = 4'd1,
        OP_NOT   = 4'd2,
        OP_PASSA = 4'd3,
        OP_SUB   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_SHL   = 4'd7,
        OP_SHR   = 4'd8,
        OP_SRA   = 4'd9,
        OP_MUL   = 4'd10
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_t;

    // Zero flag set: matches Q_Out=0 after reset.
    localparam logic [2:0] NZP_RESET = 3'b010;

endpackage

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of A*B,
// one partial product per step; prod already includes the current step.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] prod,
    output logic             last
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    count_reg;

    // Exposing the post-step sum lets the caller capture the result on the final step edge.
    assign prod = acc_reg + (b_reg[0] ? a_reg : '0);
    assign last = (count_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (load) begin
            a_reg     <= A;
            b_reg     <= B;
            acc_reg   <= '0;
            count_reg <= '0;
        end else if (step) begin
            acc_reg   <= prod;
            a_reg     <= a_reg << 1;
            b_reg     <= b_reg >> 1;
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and NZP/V flags.
// Build option ALU_SEQ_MUL_EN enables the iterative multiplier (op 10).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Q_Out,
    output logic [2:0]       nzp,
    output logic             v
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    alu_op_t          op_e;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [WIDTH-1:0] b_neg;
    logic [WIDTH-1:0] alu_res;
    logic             alu_v;
    logic             write_alu;
    logic             write_mul;
    logic [WIDTH-1:0] mul_res;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] x);
        logic z;
        z = (x == '0);
        return {x[MSB], z, ~x[MSB] & ~z};
    endfunction

    assign op_e    = alu_op_t'(op);
    assign shamt   = B[SHW-1:0];
    assign add_res = A + B;
    assign sub_res = A - B;
    assign b_neg   = ~B + 1'b1;

    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (op_e)
            OP_ADD: begin
                alu_res = add_res;
                alu_v   = (A[MSB] == B[MSB]) && (add_res[MSB] != A[MSB]);
            end
            OP_AND:   alu_res = A & B;
            OP_NOT:   alu_res = ~A;
            OP_PASSA: alu_res = A;
            OP_SUB: begin
                alu_res = sub_res;
                alu_v   = (A[MSB] == b_neg[MSB]) && (sub_res[MSB] != A[MSB]);
            end
            OP_OR:    alu_res = A | B;
            OP_XOR:   alu_res = A ^ B;
            OP_SHL:   alu_res = A << shamt;
            OP_SHR:   alu_res = A >> shamt;
            OP_SRA:   alu_res = WIDTH'($signed(A) >>> shamt);
            // MUL is handled by the iterative path; reserved codes yield zero.
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    alu_state_t state_reg;
    alu_state_t state_next;
    logic       mul_load;
    logic       mul_step;
    logic       mul_last;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk  (Clk),
        .srst (Reset),
        .load (mul_load),
        .step (mul_step),
        .A    (A),
        .B    (B),
        .prod (mul_res),
        .last (mul_last)
    );

    always_comb begin
        state_next = state_reg;
        write_alu  = 1'b0;
        write_mul  = 1'b0;
        mul_load   = 1'b0;
        mul_step   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (op_e == OP_MUL) begin
                        mul_load   = 1'b1;
                        state_next = MUL;
                    end else begin
                        write_alu = 1'b1;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    write_mul  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    assign ready = (state_reg == IDLE);
`else
    // Without the multiplier every request completes in one cycle.
    assign write_alu = start;
    assign write_mul = 1'b0;
    assign mul_res   = '0;
    assign ready     = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            done  <= 1'b0;
            Q_Out <= '0;
            nzp   <= NZP_RESET;
            v     <= 1'b0;
        end else begin
            done <= write_alu | write_mul;
            if (write_alu) begin
                Q_Out <= alu_res;
                nzp   <= nzp_of(alu_res);
                v     <= alu_v;
            end else if (write_mul) begin
                Q_Out <= mul_res;
                nzp   <= nzp_of(mul_res);
                v     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=16; MUL expectations
// follow the ALU_SEQ_MUL_EN build option.
module tb_alu_seq;

    localparam int WIDTH = 16;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Q_Out;
    logic [2:0]       nzp;
    logic             v;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .ready (ready),
        .done  (done),
        .Q_Out (Q_Out),
        .nzp   (nzp),
        .v     (v)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one single-cycle op, then check the result cycle and the cycle after.
    task automatic do_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eq,
                         input logic [2:0] enzp, input logic ev);
        start = 1'b1; op = o; A = a; B = b;
        tick();
        start = 1'b0;
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".q"},    32'(Q_Out), 32'(eq));
        check({tag, ".nzp"},  32'(nzp), 32'(enzp));
        check({tag, ".v"},    32'(v), 32'(ev));
        $display("op %0d A=%h B=%h -> Q=%h nzp=%b v=%b", o, a, b, Q_Out, nzp, v);
        tick();
        check({tag, ".done_low"}, 32'(done), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".q"},     32'(Q_Out), 32'd0);
        check({tag, ".nzp"},   32'(nzp), 32'b010);
        check({tag, ".v"},     32'(v), 32'd0);
        check({tag, ".ready"}, 32'(ready), 32'd1);
        check({tag, ".done"},  32'(done), 32'd0);
    endtask

    initial begin
        int low_cnt;
        int done_cnt;
        Reset = 1'b1; start = 1'b0; op = '0; A = '0; B = '0;
        tick();
        tick();
        Reset = 1'b0;
        check_reset("rst0");
        $display("reset: Q=%h nzp=%b v=%b ready=%b", Q_Out, nzp, v, ready);

        // Legacy ops
        do_op("add_ovf", 4'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1'b1);
        do_op("not",     4'd2, 16'hFFFF, 16'h0000, 16'h0000, 3'b010, 1'b0);
        do_op("passa",   4'd3, 16'h1234, 16'hAAAA, 16'h1234, 3'b001, 1'b0);
        do_op("and",     4'd1, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100, 1'b0);

        // New ops
        do_op("sub",     4'd4, 16'h0003, 16'h0005, 16'hFFFE, 3'b100, 1'b0);
        do_op("sub_ovf", 4'd4, 16'h8000, 16'h0001, 16'h7FFF, 3'b001, 1'b1);
        do_op("sra",     4'd9, 16'h8000, 16'h0013, 16'hF000, 3'b100, 1'b0);
        do_op("shr",     4'd8, 16'h8000, 16'h0003, 16'h1000, 3'b001, 1'b0);
        do_op("shl",     4'd7, 16'h0001, 16'h001F, 16'h8000, 3'b100, 1'b0);
        do_op("xor",     4'd6, 16'hF0F0, 16'hFF00, 16'h0FF0, 3'b001, 1'b0);
        do_op("or",      4'd5, 16'h00F0, 16'h0F00, 16'h0FF0, 3'b001, 1'b0);

        // Reset mid-run with a non-zero result held
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_reset("rst_mid");
        $display("mid reset: Q=%h nzp=%b", Q_Out, nzp);

        // Back-to-back issue with start held four cycles
        start = 1'b1; op = 4'd0; A = 16'h0001; B = 16'h0002;
        tick();
        check("b2b0.done", 32'(done), 32'd1);
        check("b2b0.q", 32'(Q_Out), 32'h0003);
        op = 4'd1; A = 16'h0006; B = 16'h0003;
        tick();
        check("b2b1.done", 32'(done), 32'd1);
        check("b2b1.q", 32'(Q_Out), 32'h0002);
        op = 4'd5; A = 16'h0004; B = 16'h0001;
        tick();
        check("b2b2.done", 32'(done), 32'd1);
        check("b2b2.q", 32'(Q_Out), 32'h0005);
        op = 4'd12; A = 16'h0005; B = 16'h0005;
        tick();
        start = 1'b0;
        check("b2b3.done", 32'(done), 32'd1);
        check("b2b3.q", 32'(Q_Out), 32'h0000);
        check("b2b3.nzp", 32'(nzp), 32'b010);
        $display("back-to-back last: Q=%h nzp=%b", Q_Out, nzp);
        tick();
        check("b2b.done_low", 32'(done), 32'd0);

        do_op("pre_mul", 4'd3, 16'h5555, 16'h0000, 16'h5555, 3'b001, 1'b0);

`ifdef ALU_SEQ_MUL_EN
        // MUL 0x0123*0x0010 with ignored start pulses while busy
        start = 1'b1; op = 4'd10; A = 16'h0123; B = 16'h0010;
        tick();
        low_cnt = (ready == 1'b0) ? 1 : 0;
        done_cnt = (done == 1'b1) ? 1 : 0;
        for (int k = 1; k < 16; k++) begin
            start = k[0]; op = 4'd0; A = 16'h0001; B = 16'h0001;
            tick();
            if (ready == 1'b0) low_cnt++;
            if (done == 1'b1) done_cnt++;
        end
        start = 1'b0;
        check("mul1.ready_low_cycles", 32'(low_cnt), 32'd16);
        check("mul1.early_done", 32'(done_cnt), 32'd0);
        check("mul1.q_held", 32'(Q_Out), 32'h5555);
        tick();
        check("mul1.done", 32'(done), 32'd1);
        check("mul1.q", 32'(Q_Out), 32'h1230);
        check("mul1.nzp", 32'(nzp), 32'b001);
        check("mul1.ready", 32'(ready), 32'd1);
        $display("mul 0123*0010 -> Q=%h", Q_Out);
        tick();
        check("mul1.done_low", 32'(done), 32'd0);
        check("mul1.q_kept", 32'(Q_Out), 32'h1230);

        // MUL 0xFFFF*0xFFFF
        start = 1'b1; op = 4'd10; A = 16'hFFFF; B = 16'hFFFF;
        tick();
        start = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        check("mul2.pre_done", 32'(done), 32'd0);
        tick();
        check("mul2.done", 32'(done), 32'd1);
        check("mul2.q", 32'(Q_Out), 32'h0001);
        check("mul2.v", 32'(v), 32'd0);
        $display("mul ffff*ffff -> Q=%h", Q_Out);
        tick();

        // Reset at MUL step 8 aborts the request
        start = 1'b1; op = 4'd10; A = 16'h0003; B = 16'h0005;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_reset("mul_abort");
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done == 1'b1) done_cnt++;
        end
        check("mul_abort.no_done", 32'(done_cnt), 32'd0);
        check("mul_abort.q", 32'(Q_Out), 32'd0);
        $display("mul abort: Q=%h done pulses=%0d", Q_Out, done_cnt);
        do_op("post_abort_add", 4'd0, 16'h0002, 16'h0002, 16'h0004, 3'b001, 1'b0);
`else
        // Without the multiplier, op 10 is reserved
        start = 1'b1; op = 4'd10; A = 16'h0123; B = 16'h0010;
        tick();
        start = 1'b0;
        low_cnt = 0;
        done_cnt = 0;
        check("mul_off.done", 32'(done), 32'd1);
        check("mul_off.q", 32'(Q_Out), 32'h0000);
        check("mul_off.nzp", 32'(nzp), 32'b010);
        check("mul_off.ready", 32'(ready), 32'd1);
        $display("op 10 (no multiplier) -> Q=%h", Q_Out);
        tick();
        check("mul_off.done_low", 32'(done), 32'd0);
        do_op("post_mul_off_add", 4'd0, 16'h0002, 16'h0002, 16'h0004, 3'b001, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
